// File: rtl/player_pkg.sv
// Shared definitions for the MP3 player front-end control sequencer.
//   state_e          : sequencer state encoding (IDLE/LOAD/PLAY, 2 bits)
//   VOL_W            : width of the volume level
//   DEBOUNCE_DEFAULT : debounce length for synthesis (10 ms at 100 MHz)
//   DEBOUNCE_SIM     : short debounce length for simulation
//   BTN_*            : bit positions of the four buttons in the event vector
package player_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_PLAY = 2'd2
  } state_e;

  localparam int VOL_W            = 4;
  localparam int DEBOUNCE_DEFAULT = 1000000;
  localparam int DEBOUNCE_SIM     = 4;

  localparam int BTN_NEXT  = 0;
  localparam int BTN_PRE   = 1;
  localparam int BTN_VPLUS = 2;
  localparam int BTN_VDEC  = 3;

endpackage

// File: rtl/player_ctrl_btn_debounce.sv
// Debouncer for one raw asynchronous push button.
//   clk     : system clock
//   rst     : asynchronous active-high reset
//   btn_raw : raw button level (asynchronous)
//   rise    : one-cycle pulse when the debounced level goes 0 -> 1
// A 2-FF synchronizer feeds a counter that runs only while the synchronized
// level differs from the debounced level. After DEBOUNCE_CYCLES consecutive
// differing cycles the debounced level follows. The rising-edge pulse is
// registered, so a raw high first sampled at edge t shows up on rise during
// the cycle after edge t+DEBOUNCE_CYCLES+2.
module btn_debounce
  import player_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic rise
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             db_q, db_d;
  logic             db_dly_q, db_dly_d;
  logic             rise_q, rise_d;

  always_comb begin
    sync1_d  = btn_raw;
    sync2_d  = sync1_q;
    db_d     = db_q;
    cnt_d    = '0;
    // Counter restarts on any cycle where the input agrees with the
    // debounced level, so a glitch must persist to be accepted.
    if (sync2_q != db_q) begin
      if (cnt_q == CNT_LAST) begin
        db_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    db_dly_d = db_q;
    rise_d   = db_q & ~db_dly_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      cnt_q    <= '0;
      db_q     <= 1'b0;
      db_dly_q <= 1'b0;
      rise_q   <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      cnt_q    <= cnt_d;
      db_q     <= db_d;
      db_dly_q <= db_dly_d;
      rise_q   <= rise_d;
    end
  end

  assign rise = rise_q;

endmodule

// File: rtl/player_ctrl.sv
// Front-end control sequencer for the MP3 player.
//   CLK, RST_BTN        : clock, asynchronous active-high reset
//   btn_*               : raw user buttons (next, pre, vol+, vol-)
//   i_finish_song       : decoder pulse, current song ended (auto-advance)
//   i_load_ack          : decoder accepts the pending load request
//   o_load_req          : load request for o_song_idx, held until acked
//   o_song_idx          : current track index
//   o_vol_level         : current volume 0..VOL_MAX
//   o_next/o_pre/o_vol_plus/o_vol_dec/o_finish_song : one-cycle strobes
//   o_busy              : high while in IDLE or LOAD
// Handshake: o_load_req is raised on entry to LOAD and stays high until the
// first cycle with i_load_ack=1; the request drops on the edge that samples
// the ack (an ack in the very first LOAD cycle is accepted).
// Track events go PLAY -> IDLE -> LOAD, so LOAD starts one cycle after the
// strobe/index-update cycle. Volume events are handled in every state.
module player_ctrl
  import player_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int NUM_SONGS       = 4,
  parameter int SONG_W          = 2,
  parameter int VOL_DEFAULT     = 8,
  parameter int VOL_MAX         = 15
) (
  input  logic              CLK,
  input  logic              RST_BTN,
  input  logic              btn_next,
  input  logic              btn_pre,
  input  logic              btn_vol_plus,
  input  logic              btn_vol_dec,
  input  logic              i_finish_song,
  input  logic              i_load_ack,
  output logic              o_load_req,
  output logic [SONG_W-1:0] o_song_idx,
  output logic [VOL_W-1:0]  o_vol_level,
  output logic              o_next,
  output logic              o_pre,
  output logic              o_vol_plus,
  output logic              o_vol_dec,
  output logic              o_finish_song,
  output logic              o_busy
);

  localparam logic [SONG_W-1:0] IDX_LAST = SONG_W'(NUM_SONGS - 1);
  localparam logic [VOL_W-1:0]  VOL_TOP  = VOL_W'(VOL_MAX);
  localparam logic [VOL_W-1:0]  VOL_RST  = VOL_W'(VOL_DEFAULT);

  logic [3:0] btn_raw;
  logic [3:0] evt;

  assign btn_raw = {btn_vol_dec, btn_vol_plus, btn_pre, btn_next};

  for (genvar g = 0; g < 4; g++) begin : g_db
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk     (CLK),
      .rst     (RST_BTN),
      .btn_raw (btn_raw[g]),
      .rise    (evt[g])
    );
  end

  state_e            state_q, state_d;
  logic [SONG_W-1:0] idx_q, idx_d;
  logic [VOL_W-1:0]  vol_q, vol_d;
  logic              load_req_q, load_req_d;
  logic              busy_q, busy_d;
  logic              next_q, next_d;
  logic              pre_q, pre_d;
  logic              vplus_q, vplus_d;
  logic              vdec_q, vdec_d;
  logic              fin_q, fin_d;

  logic [SONG_W-1:0] idx_inc, idx_dec;
  assign idx_inc = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
  assign idx_dec = (idx_q == '0) ? IDX_LAST : idx_q - 1'b1;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    vol_d   = vol_q;
    next_d  = 1'b0;
    pre_d   = 1'b0;
    vplus_d = 1'b0;
    vdec_d  = 1'b0;
    fin_d   = 1'b0;

    case (state_q)
      ST_IDLE: state_d = ST_LOAD;
      ST_LOAD: if (i_load_ack) state_d = ST_PLAY;
      ST_PLAY: begin
        // Priority finish > next > pre; losing events are dropped.
        if (i_finish_song) begin
          idx_d   = idx_inc;
          fin_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (evt[BTN_NEXT]) begin
          idx_d   = idx_inc;
          next_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (evt[BTN_PRE]) begin
          idx_d   = idx_dec;
          pre_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Opposing volume presses cancel; saturated presses still strobe.
    if (evt[BTN_VPLUS] && !evt[BTN_VDEC]) begin
      vplus_d = 1'b1;
      if (vol_q != VOL_TOP) vol_d = vol_q + 1'b1;
    end else if (evt[BTN_VDEC] && !evt[BTN_VPLUS]) begin
      vdec_d = 1'b1;
      if (vol_q != '0) vol_d = vol_q - 1'b1;
    end

    load_req_d = (state_d == ST_LOAD);
    busy_d     = (state_d != ST_PLAY);
  end

  always_ff @(posedge CLK or posedge RST_BTN) begin
    if (RST_BTN) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      vol_q      <= VOL_RST;
      load_req_q <= 1'b0;
      busy_q     <= 1'b1;
      next_q     <= 1'b0;
      pre_q      <= 1'b0;
      vplus_q    <= 1'b0;
      vdec_q     <= 1'b0;
      fin_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      vol_q      <= vol_d;
      load_req_q <= load_req_d;
      busy_q     <= busy_d;
      next_q     <= next_d;
      pre_q      <= pre_d;
      vplus_q    <= vplus_d;
      vdec_q     <= vdec_d;
      fin_q      <= fin_d;
    end
  end

  assign o_load_req    = load_req_q;
  assign o_song_idx    = idx_q;
  assign o_vol_level   = vol_q;
  assign o_next        = next_q;
  assign o_pre         = pre_q;
  assign o_vol_plus    = vplus_q;
  assign o_vol_dec     = vdec_q;
  assign o_finish_song = fin_q;
  assign o_busy        = busy_q;

endmodule

// File: tb/tb_player_ctrl.sv
// Directed self-checking bench for player_ctrl with a 4-cycle debounce.
module tb_player_ctrl;
  import player_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       btn_next = 1'b0, btn_pre = 1'b0, btn_vol_plus = 1'b0, btn_vol_dec = 1'b0;
  logic       i_finish_song = 1'b0, i_load_ack = 1'b0;
  logic       o_load_req, o_next, o_pre, o_vol_plus, o_vol_dec, o_finish_song, o_busy;
  logic [1:0] o_song_idx;
  logic [3:0] o_vol_level;

  player_ctrl #(
    .DEBOUNCE_CYCLES(DEBOUNCE_SIM),
    .NUM_SONGS      (4),
    .SONG_W         (2),
    .VOL_DEFAULT    (8),
    .VOL_MAX        (15)
  ) dut (
    .CLK          (clk),
    .RST_BTN      (rst),
    .btn_next     (btn_next),
    .btn_pre      (btn_pre),
    .btn_vol_plus (btn_vol_plus),
    .btn_vol_dec  (btn_vol_dec),
    .i_finish_song(i_finish_song),
    .i_load_ack   (i_load_ack),
    .o_load_req   (o_load_req),
    .o_song_idx   (o_song_idx),
    .o_vol_level  (o_vol_level),
    .o_next       (o_next),
    .o_pre        (o_pre),
    .o_vol_plus   (o_vol_plus),
    .o_vol_dec    (o_vol_dec),
    .o_finish_song(o_finish_song),
    .o_busy       (o_busy)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  int strobe_all;  // all strobes seen during the last press
  int fin_cnt;     // o_finish_song pulses during the last press
  int lr_first;    // first tick with o_load_req high during the last press

  // mask bit order: {vol-, vol+, pre, next}; mon selects
  // {finish, vol-, vol+, pre, next}[mon] as the monitored strobe.
  task automatic press(input logic [3:0] mask, input int hold, input int total,
                       input int fin_at, input int mon,
                       output int cnt, output int first);
    logic [4:0] s;
    cnt = 0; first = 0; strobe_all = 0; fin_cnt = 0; lr_first = 0;
    for (int i = 1; i <= total; i++) begin
      {btn_vol_dec, btn_vol_plus, btn_pre, btn_next} = (i <= hold) ? mask : 4'b0000;
      i_finish_song = (i == fin_at);
      tick;
      s = {o_finish_song, o_vol_dec, o_vol_plus, o_pre, o_next};
      if (s[mon]) begin
        cnt++;
        if (first == 0) first = i;
      end
      strobe_all += $countones(s);
      if (o_finish_song) fin_cnt++;
      if (o_load_req && lr_first == 0) lr_first = i;
    end
    {btn_vol_dec, btn_vol_plus, btn_pre, btn_next} = 4'b0000;
    i_finish_song = 1'b0;
  endtask

  task automatic do_ack(input string tag);
    check({tag, "_req_before_ack"}, o_load_req, 1);
    i_load_ack = 1'b1;
    tick;
    i_load_ack = 1'b0;
    check({tag, "_req_after_ack"}, o_load_req, 0);
    check({tag, "_busy_after_ack"}, o_busy, 0);
  endtask

  // ---------------- directed stimulus ----------------
  int cnt, first, exp_vol, tot;

  initial begin
    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_load_req", o_load_req, 0);
    check("rst_idx", o_song_idx, 0);
    check("rst_vol", o_vol_level, 8);
    check("rst_busy", o_busy, 1);
    check("rst_strobes", {o_next, o_pre, o_vol_plus, o_vol_dec, o_finish_song}, 0);

    // Start-up: IDLE -> LOAD, ack held low for 5 cycles
    rst = 1'b0;
    tick;
    check("boot_req", o_load_req, 1);
    check("boot_busy", o_busy, 1);
    repeat (4) tick;
    check("boot_req_held", o_load_req, 1);
    check("boot_idx", o_song_idx, 0);
    do_ack("boot");

    // Next held 10 cycles: one strobe at tick 8, LOAD at tick 9
    press(4'b0001, 10, 20, 0, 0, cnt, first);
    check("next_cnt", cnt, 1);
    check("next_latency", first, 8);
    check("next_idx", o_song_idx, 1);
    check("next_reload_tick", lr_first, 9);
    check("next_total_strobes", strobe_all, 1);
    do_ack("next");

    // 3-cycle glitches are rejected
    for (int k = 0; k < 2; k++) begin
      press(4'b0001, 3, 12, 0, 0, cnt, first);
      check("glitch_strobes", strobe_all, 0);
      check("glitch_idx", o_song_idx, 1);
      check("glitch_no_req", o_load_req, 0);
    end

    // Previous: 1 -> 0, then wrap 0 -> 3
    press(4'b0010, 6, 12, 0, 1, cnt, first);
    check("pre1_cnt", cnt, 1);
    check("pre1_idx", o_song_idx, 0);
    do_ack("pre1");
    press(4'b0010, 6, 12, 0, 1, cnt, first);
    check("pre_wrap_cnt", cnt, 1);
    check("pre_wrap_idx", o_song_idx, 3);
    do_ack("pre2");

    // Auto-advance wraps 3 -> 0 with finish strobe only
    i_finish_song = 1'b1;
    tick;
    i_finish_song = 1'b0;
    check("fin_strobe", o_finish_song, 1);
    check("fin_no_next", o_next, 0);
    check("fin_idx", o_song_idx, 0);
    tick;
    check("fin_strobe_single", o_finish_song, 0);
    check("fin_reload", o_load_req, 1);
    // finish while in LOAD is ignored
    i_finish_song = 1'b1;
    tick;
    i_finish_song = 1'b0;
    check("fin_in_load_strobe", o_finish_song, 0);
    check("fin_in_load_idx", o_song_idx, 0);
    do_ack("fin");

    // Coincident finish and next: finish wins, single advance 0 -> 1
    press(4'b0001, 6, 12, 8, 0, cnt, first);
    check("prio_next_cnt", cnt, 0);
    check("prio_fin_cnt", fin_cnt, 1);
    check("prio_idx", o_song_idx, 1);
    do_ack("prio");

    // Volume up 9 times from 8: saturates at 15, every press strobes
    exp_vol = 8;
    tot = 0;
    for (int k = 0; k < 9; k++) begin
      press(4'b0100, 5, 10, 0, 2, cnt, first);
      tot += cnt;
      if (exp_vol < 15) exp_vol++;
      check("vup_level", o_vol_level, exp_vol);
    end
    check("vup_strobes", tot, 9);
    check("vup_final", o_vol_level, 15);

    // vol+ and vol- together: no change, no strobe
    press(4'b1100, 6, 12, 0, 2, cnt, first);
    check("vboth_strobes", strobe_all, 0);
    check("vboth_level", o_vol_level, 15);

    // Volume down 16 times from 15: saturates at 0
    exp_vol = 15;
    tot = 0;
    for (int k = 0; k < 16; k++) begin
      press(4'b1000, 5, 10, 0, 3, cnt, first);
      tot += cnt;
      if (exp_vol > 0) exp_vol--;
      check("vdn_level", o_vol_level, exp_vol);
    end
    check("vdn_strobes", tot, 16);
    check("vdn_idx_kept", o_song_idx, 1);

    // Reset asserted mid-LOAD drops the request immediately
    press(4'b0001, 10, 9, 0, 0, cnt, first);
    check("rl_req_high", o_load_req, 1);
    check("rl_idx_before", o_song_idx, 2);
    #2;
    rst = 1'b1;
    #1;
    check("rl_req_dropped", o_load_req, 0);
    check("rl_vol", o_vol_level, 8);
    check("rl_idx", o_song_idx, 0);
    check("rl_busy", o_busy, 1);
    rst = 1'b0;
    tick;
    check("rl_reboot_req", o_load_req, 1);
    check("rl_reboot_idx", o_song_idx, 0);

    // ---------------- final report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
